// File: rtl/ram512x32_arb.sv
// ---------------------------------------------------------------------------
// ram512x32_arb
//
// Arbiter and access sequencer placed in front of the 512x32 single-port SRAM
// macro wrapper. Two requesters share the RAM: port 0 is the core data bus
// and port 1 is the debug/loader bus. Only one RAM access is in flight at a
// time. Each access walks IDLE -> ACC -> RESP.
//
// Parameters
//   RR         1 = round-robin between the ports; 0 = port 0 always wins
//
// Ports
//   clk_i      clock, all state changes on the rising edge
//   rst_in     synchronous active-low reset
//   mX_stb_i   request from port X; held high until that port sees ack
//   mX_we_i    1 = write, 0 = read
//   mX_sel_i   byte enables, bit i covers byte [8i+7:8i]
//   mX_adr_i   word address
//   mX_dat_i   write data
//   mX_ack_o   one-cycle acknowledge for port X
//   mX_dat_o   read data for port X; valid with ack, zero otherwise
//   ram_cen_o  RAM chip enable, high for exactly one cycle per access
//   ram_wen_o  RAM write enable
//   ram_sel_o  RAM byte select
//   ram_adr_o  RAM address
//   ram_dat_o  RAM write data
//   ram_dat_i  RAM read data, valid the cycle after the enabled edge
// ---------------------------------------------------------------------------
module ram512x32_arb #(
  parameter bit RR = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_in,

  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [8:0]  m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic [31:0] m0_dat_o,

  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [8:0]  m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic [31:0] m1_dat_o,

  output logic        ram_cen_o,
  output logic        ram_wen_o,
  output logic [3:0]  ram_sel_o,
  output logic [8:0]  ram_adr_o,
  output logic [31:0] ram_dat_o,
  input  logic [31:0] ram_dat_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        gnt_q;
  logic        last_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [8:0]  adr_q;
  logic [31:0] dat_q;

  logic        grant;
  logic        win;
  logic        in_acc;
  logic        in_resp;

  // Next-state and arbitration. A grant can only happen in IDLE, so a new
  // request never overlaps an access that is already in flight. On a tie the
  // round-robin pointer hands the RAM to the port that did not go last.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    win     = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_stb_i || m1_stb_i) begin
          grant   = 1'b1;
          state_d = ACC;
          if (m0_stb_i && m1_stb_i) begin
            win = RR ? ~last_q : 1'b0;
          end else begin
            win = m1_stb_i;
          end
        end
      end
      ACC:     state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and the RAM-facing request registers. The winner's
  // request is captured at grant time, so later changes on its bus are
  // ignored. The pointer resets to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      sel_q   <= 4'h0;
      adr_q   <= 9'h000;
      dat_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        gnt_q  <= win;
        last_q <= win;
        we_q   <= win ? m1_we_i  : m0_we_i;
        sel_q  <= win ? m1_sel_i : m0_sel_i;
        adr_q  <= win ? m1_adr_i : m0_adr_i;
        dat_q  <= win ? m1_dat_i : m0_dat_i;
      end
    end
  end

  // The ack is gated by the live strobe so that a requester which walked away
  // after grant is not acked. It is also gated by reset, so a reset that
  // lands in RESP never shows an ack.
  assign in_acc  = (state_q == ACC);
  assign in_resp = (state_q == RESP) && rst_in;

  assign ram_cen_o = in_acc;
  assign ram_wen_o = in_acc && we_q;
  assign ram_sel_o = sel_q;
  assign ram_adr_o = adr_q;
  assign ram_dat_o = dat_q;

  assign m0_ack_o = in_resp && !gnt_q && m0_stb_i;
  assign m1_ack_o = in_resp &&  gnt_q && m1_stb_i;

  assign m0_dat_o = (m0_ack_o && !we_q) ? ram_dat_i : 32'h0;
  assign m1_dat_o = (m1_ack_o && !we_q) ? ram_dat_i : 32'h0;

endmodule

// File: tb/tb_ram512x32_arb.sv
// ---------------------------------------------------------------------------
// tb_ram512x32_arb
//
// Directed bench for ram512x32_arb. Instance 0 uses round-robin arbitration
// and instance 1 uses fixed priority. Each instance drives its own
// behavioural 512x32 SRAM with byte-enabled writes and registered reads.
// ---------------------------------------------------------------------------
module tb_ram512x32_arb;

  logic        clk;
  logic        rst_n;

  logic        stb  [2][2];
  logic        we   [2][2];
  logic [3:0]  sel  [2][2];
  logic [8:0]  adr  [2][2];
  logic [31:0] wdat [2][2];
  logic        ack  [2][2];
  logic [31:0] rdat [2][2];

  logic        cen   [2];
  logic        wen   [2];
  logic [3:0]  rsel  [2];
  logic [8:0]  radr  [2];
  logic [31:0] rwdat [2];
  logic [31:0] rrdat [2];

  logic [31:0] mem [2][512];

  int checks;
  int failures;

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  ram512x32_arb #(.RR(1'b1)) u_rr (
    .clk_i     (clk),
    .rst_in    (rst_n),
    .m0_stb_i  (stb[0][0]),
    .m0_we_i   (we[0][0]),
    .m0_sel_i  (sel[0][0]),
    .m0_adr_i  (adr[0][0]),
    .m0_dat_i  (wdat[0][0]),
    .m0_ack_o  (ack[0][0]),
    .m0_dat_o  (rdat[0][0]),
    .m1_stb_i  (stb[0][1]),
    .m1_we_i   (we[0][1]),
    .m1_sel_i  (sel[0][1]),
    .m1_adr_i  (adr[0][1]),
    .m1_dat_i  (wdat[0][1]),
    .m1_ack_o  (ack[0][1]),
    .m1_dat_o  (rdat[0][1]),
    .ram_cen_o (cen[0]),
    .ram_wen_o (wen[0]),
    .ram_sel_o (rsel[0]),
    .ram_adr_o (radr[0]),
    .ram_dat_o (rwdat[0]),
    .ram_dat_i (rrdat[0])
  );

  ram512x32_arb #(.RR(1'b0)) u_fp (
    .clk_i     (clk),
    .rst_in    (rst_n),
    .m0_stb_i  (stb[1][0]),
    .m0_we_i   (we[1][0]),
    .m0_sel_i  (sel[1][0]),
    .m0_adr_i  (adr[1][0]),
    .m0_dat_i  (wdat[1][0]),
    .m0_ack_o  (ack[1][0]),
    .m0_dat_o  (rdat[1][0]),
    .m1_stb_i  (stb[1][1]),
    .m1_we_i   (we[1][1]),
    .m1_sel_i  (sel[1][1]),
    .m1_adr_i  (adr[1][1]),
    .m1_dat_i  (wdat[1][1]),
    .m1_ack_o  (ack[1][1]),
    .m1_dat_o  (rdat[1][1]),
    .ram_cen_o (cen[1]),
    .ram_wen_o (wen[1]),
    .ram_sel_o (rsel[1]),
    .ram_adr_o (radr[1]),
    .ram_dat_o (rwdat[1]),
    .ram_dat_i (rrdat[1])
  );

  // Behavioural SRAM for both instances: byte-enabled write, or a read whose
  // data appears the cycle after the enabled edge.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cen[i]) begin
        if (wen[i]) begin
          for (int b = 0; b < 4; b++) begin
            if (rsel[i][b]) mem[i][radr[i]][8*b +: 8] <= rwdat[i][8*b +: 8];
          end
        end else begin
          rrdat[i] <= mem[i][radr[i]];
        end
      end
    end
  end

  // Step to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit inst, input bit port, input logic s,
                               input logic w, input logic [3:0] se,
                               input logic [8:0] a, input logic [31:0] d);
    stb[inst][port]  = s;
    we[inst][port]   = w;
    sel[inst][port]  = se;
    adr[inst][port]  = a;
    wdat[inst][port] = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One uncontended access: ACC, RESP with ack, then back to IDLE.
  task automatic access(input bit inst, input bit port, input logic w,
                        input logic [3:0] se, input logic [8:0] a,
                        input logic [31:0] d, input logic [31:0] exp);
    applyStimulus(inst, port, 1'b1, w, se, a, d);
    tick();
    checkOutput("acc_cen", 32'(cen[inst]), 32'd1);
    checkOutput("acc_wen", 32'(wen[inst]), 32'(w));
    checkOutput("acc_adr", 32'(radr[inst]), 32'(a));
    checkOutput("acc_sel", 32'(rsel[inst]), 32'(se));
    if (w) checkOutput("acc_wdat", rwdat[inst], d);
    tick();
    checkOutput("resp_ack", 32'(ack[inst][port]), 32'd1);
    checkOutput("resp_dat", rdat[inst][port], w ? 32'h0 : exp);
    checkOutput("resp_other_ack", 32'(ack[inst][port ^ 1'b1]), 32'd0);
    applyStimulus(inst, port, 1'b0, w, se, a, d);
    tick();
    checkOutput("idle_cen", 32'(cen[inst]), 32'd0);
    checkOutput("idle_ack", 32'(ack[inst][port]), 32'd0);
  endtask

  initial begin
    bit g;
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        applyStimulus(i[0], p[0], 1'b0, 1'b0, 4'h0, 9'h000, 32'h0);
      end
    end

    // Reset held for three edges while both round-robin ports request writes.
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 9'h010, 32'h12345678);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 9'h020, 32'h9ABCDEF0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("rst_ram_ctl", 32'({cen[0], wen[0], rsel[0], radr[0]}), 32'h0);
      checkOutput("rst_ram_wdat", rwdat[0], 32'h0);
      checkOutput("rst_acks", 32'({ack[0][0], ack[0][1], ack[1][0], ack[1][1]}), 32'h0);
      checkOutput("rst_rdat", rdat[0][0] | rdat[0][1], 32'h0);
    end
    rst_n = 1'b1;

    // First tie after reset goes to port 0, then port 1 gets its turn.
    tick();
    checkOutput("first_cen", 32'(cen[0]), 32'd1);
    checkOutput("first_adr", 32'(radr[0]), 32'h010);
    tick();
    checkOutput("first_ack0", 32'(ack[0][0]), 32'd1);
    checkOutput("first_ack1", 32'(ack[0][1]), 32'd0);
    checkOutput("first_wr_dat", rdat[0][0], 32'h0);
    stb[0][0] = 1'b0;
    tick();
    checkOutput("first_idle_acks", 32'({ack[0][0], ack[0][1]}), 32'h0);
    tick();
    checkOutput("second_adr", 32'(radr[0]), 32'h020);
    tick();
    checkOutput("second_ack1", 32'(ack[0][1]), 32'd1);
    stb[0][1] = 1'b0;
    tick();

    // Full-word write then read back on port 0.
    access(1'b0, 1'b0, 1'b1, 4'hF, 9'h1A5, 32'hDEADBEEF, 32'h0);
    access(1'b0, 1'b0, 1'b0, 4'hF, 9'h1A5, 32'h0, 32'hDEADBEEF);

    // Partial write merges bytes 0 and 2 into the earlier word.
    access(1'b0, 1'b0, 1'b1, 4'hF, 9'h003, 32'h11223344, 32'h0);
    access(1'b0, 1'b0, 1'b1, 4'b0101, 9'h003, 32'hAABBCCDD, 32'h0);
    access(1'b0, 1'b0, 1'b0, 4'hF, 9'h003, 32'h0, 32'h11BB33DD);

    // Round-robin contention: port 0 went last, so port 1 starts.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 9'h1A5, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 9'h003, 32'h0);
    for (int k = 0; k < 4; k++) begin
      g = (k % 2 == 0);
      tick();
      checkOutput("rr_cen", 32'(cen[0]), 32'd1);
      checkOutput("rr_adr", 32'(radr[0]), g ? 32'h003 : 32'h1A5);
      tick();
      checkOutput("rr_ack_gnt", 32'(ack[0][g]), 32'd1);
      checkOutput("rr_dat_gnt", rdat[0][g], g ? 32'h11BB33DD : 32'hDEADBEEF);
      checkOutput("rr_ack_other", 32'(ack[0][g ^ 1'b1]), 32'd0);
      checkOutput("rr_dat_other", rdat[0][g ^ 1'b1], 32'h0);
      tick();
      checkOutput("rr_ack_pulse", 32'({ack[0][0], ack[0][1]}), 32'h0);
    end
    stb[0][0] = 1'b0;
    stb[0][1] = 1'b0;

    // Port 1 abandons a write during ACC: write lands, no ack.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 9'h100, 32'h0000CAFE);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 9'h000, 32'h0);
    checkOutput("abort_wen", 32'(wen[0]), 32'd1);
    checkOutput("abort_adr", 32'(radr[0]), 32'h100);
    checkOutput("abort_wdat", rwdat[0], 32'h0000CAFE);
    tick();
    checkOutput("abort_no_ack", 32'(ack[0][1]), 32'd0);
    checkOutput("abort_no_dat", rdat[0][1], 32'h0);
    tick();
    access(1'b0, 1'b1, 1'b0, 4'hF, 9'h100, 32'h0, 32'h0000CAFE);

    // Fixed priority: port 1 starves while port 0 keeps requesting.
    access(1'b1, 1'b0, 1'b1, 4'hF, 9'h010, 32'h01010101, 32'h0);
    access(1'b1, 1'b1, 1'b1, 4'hF, 9'h020, 32'h02020202, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 9'h010, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 9'h020, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("fp_adr", 32'(radr[1]), 32'h010);
      tick();
      checkOutput("fp_ack0", 32'(ack[1][0]), 32'd1);
      checkOutput("fp_dat0", rdat[1][0], 32'h01010101);
      checkOutput("fp_ack1_starved", 32'(ack[1][1]), 32'd0);
      tick();
      checkOutput("fp_idle_ack1", 32'(ack[1][1]), 32'd0);
    end
    stb[1][0] = 1'b0;
    tick();
    checkOutput("fp_p1_adr", 32'(radr[1]), 32'h020);
    tick();
    checkOutput("fp_p1_ack", 32'(ack[1][1]), 32'd1);
    checkOutput("fp_p1_dat", rdat[1][1], 32'h02020202);
    stb[1][1] = 1'b0;
    tick();

    // Reset asserted during RESP: ack suppressed, back to IDLE next cycle.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 9'h1A5, 32'h0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("rstresp_no_ack", 32'(ack[0][0]), 32'd0);
    checkOutput("rstresp_no_dat", rdat[0][0], 32'h0);
    tick();
    checkOutput("rstresp_cen", 32'(cen[0]), 32'd0);
    checkOutput("rstresp_adr", 32'(radr[0]), 32'h0);
    checkOutput("rstresp_ack", 32'(ack[0][0]), 32'd0);
    rst_n = 1'b1;
    stb[0][0] = 1'b0;
    tick();
    checkOutput("rstresp_idle_cen", 32'(cen[0]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
